// File: rtl/serial_adder_n_if.sv
// Handshake/result bundle for serial_adder_n.
// Carries the optional sub request when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_n_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder_n.sv
// Multi-cycle adder summing DIGIT bits per clock through a registered carry.
// Define SERIAL_ADDER_SUB_EN to add the sub (a-b) request.
module serial_adder_n #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input logic             clk,
    input logic             rst_n,
    serial_adder_n_if.slave bus
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [DIGIT:0]   dsum;
    logic [WIDTH-1:0] acc_nxt;
    logic             last;
    logic [WIDTH-1:0] b_in;
    logic             c_in;

`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtract: invert B and inject a carry of one.
    assign b_in = bus.sub ? ~bus.b : bus.b;
    assign c_in = bus.sub ? 1'b1 : bus.cin;
`else
    assign b_in = bus.b;
    assign c_in = bus.cin;
`endif

    assign dsum = {1'b0, a_sh[DIGIT-1:0]}
                + {1'b0, b_sh[DIGIT-1:0]}
                + (DIGIT+1)'(carry);

    // New digit enters at the MSB end; after STEPS digits acc is aligned.
    assign acc_nxt = WIDTH'({dsum[DIGIT-1:0], acc} >> DIGIT);
    assign last    = (cnt == CW'(STEPS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.sum  <= '0;
            bus.cout <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_sh     <= bus.a;
                        b_sh     <= b_in;
                        carry    <= c_in;
                        acc      <= '0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state    <= IDLE;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    acc   <= acc_nxt;
                    carry <= dsum[DIGIT];
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        bus.sum  <= acc_nxt;
                        bus.cout <= dsum[DIGIT];
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_n.sv
// Bench for serial_adder_n: DIGIT=1, 4 and 8 instances against an arithmetic model.
// Exercises the sub path too when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_n;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic multi = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [8:0] prev = '0;

    always #5 clk = ~clk;

    serial_adder_n_if #(.WIDTH(8)) i1 ();
    serial_adder_n_if #(.WIDTH(8)) i4 ();
    serial_adder_n_if #(.WIDTH(8)) i8 ();

    // Wider-digit instances only start when the step asks for them.
    assign i4.start = i1.start & multi;
    assign i4.a     = i1.a;
    assign i4.b     = i1.b;
    assign i4.cin   = i1.cin;
    assign i8.start = i1.start & multi;
    assign i8.a     = i1.a;
    assign i8.b     = i1.b;
    assign i8.cin   = i1.cin;
`ifdef SERIAL_ADDER_SUB_EN
    assign i4.sub   = i1.sub;
    assign i8.sub   = i1.sub;
`endif

    serial_adder_n #(.WIDTH(8), .DIGIT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1));
    serial_adder_n #(.WIDTH(8), .DIGIT(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(i4));
    serial_adder_n #(.WIDTH(8), .DIGIT(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(i8));

    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic cin, input logic sub);
        int r;
        if (sub) begin
            r = int'(a) - int'(b);
            return {(a >= b), 8'(r)};
        end
        r = int'(a) + int'(b) + int'(cin);
        return 9'(r);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic sub, input logic m, input int pulse_at,
                         input bit go_idle);
        logic [8:0] e;
        e = model(a, b, cin, sub);
        multi = m;
        i1.a = a;
        i1.b = b;
        i1.cin = cin;
`ifdef SERIAL_ADDER_SUB_EN
        i1.sub = sub;
`endif
        i1.start = 1'b1;
        step();
        i1.start = 1'b0;
        chk("busy_e0", 32'(i1.busy), 32'd1);
        chk("done_e0", 32'(i1.done), 32'd0);
        if (m) begin
            chk("busy4_e0", 32'(i4.busy), 32'd1);
            chk("busy8_e0", 32'(i8.busy), 32'd1);
        end
        for (int k = 1; k <= 8; k++) begin
            if (k == pulse_at) begin
                i1.start = 1'b1;
                i1.a = 8'h11;
            end
            step();
            i1.start = 1'b0;
            chk("done1", 32'(i1.done), 32'(k == 8));
            chk("busy1", 32'(i1.busy), 32'(k < 8));
            if (k < 8) chk("sum1_hold", 32'({i1.cout, i1.sum}), 32'(prev));
            else       chk("res1", 32'({i1.cout, i1.sum}), 32'(e));
            if (m) begin
                chk("done4", 32'(i4.done), 32'(k == 2));
                chk("done8", 32'(i8.done), 32'(k == 1));
                if (k == 2) chk("res4", 32'({i4.cout, i4.sum}), 32'(e));
                if (k == 1) chk("res8", 32'({i8.cout, i8.sum}), 32'(e));
            end
        end
        prev = e;
        if (go_idle) begin
            step();
            chk("done_low", 32'(i1.done), 32'd0);
            chk("idle_busy", 32'(i1.busy), 32'd0);
            chk("res_hold", 32'({i1.cout, i1.sum}), 32'(e));
        end
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic       rs;
        bit         rg;
        i1.start = 1'b0;
        i1.a = '0;
        i1.b = '0;
        i1.cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        i1.sub = 1'b0;
`endif
        rst_n = 1'b0;
        step();
        step();
        chk("rst1", 32'({i1.busy, i1.done, i1.cout, i1.sum}), 32'd0);
        chk("rst4", 32'({i4.busy, i4.done, i4.cout, i4.sum}), 32'd0);
        chk("rst8", 32'({i8.busy, i8.done, i8.cout, i8.sum}), 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle1", 32'({i1.busy, i1.done}), 32'd0);

        do_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1, 0, 1'b1);
        chk("t1_const", 32'({i1.cout, i1.sum}), 32'h096);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 0, 1'b1);
        chk("t2a_const", 32'({i1.cout, i1.sum}), 32'h100);
        do_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 0, 1'b1);
        chk("t2b_const", 32'({i1.cout, i1.sum}), 32'h1FF);

        // Mid-run start ignored, then back-to-back accept from DONE.
        do_op(8'h33, 8'h44, 1'b1, 1'b0, 1'b0, 3, 1'b0);
        do_op(8'h9C, 8'h78, 1'b0, 1'b0, 1'b1, 0, 1'b1);
        chk("t5_const", 32'({i4.cout, i4.sum}), 32'h114);

        // Reset in the middle of a run aborts it.
        multi = 1'b0;
        i1.a = 8'h5A;
        i1.b = 8'h3C;
        i1.start = 1'b1;
        step();
        i1.start = 1'b0;
        for (int k = 0; k < 3; k++) step();
        chk("t4_busy_pre", 32'(i1.busy), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t4_rst", 32'({i1.busy, i1.done, i1.cout, i1.sum}), 32'd0);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("t4_nodone", 32'({i1.busy, i1.done}), 32'd0);
        end
        prev = '0;

`ifdef SERIAL_ADDER_SUB_EN
        do_op(8'h10, 8'h01, 1'b0, 1'b1, 1'b1, 0, 1'b1);
        chk("t6a_const", 32'({i1.cout, i1.sum}), 32'h10F);
        do_op(8'h01, 8'h02, 1'b1, 1'b1, 1'b1, 0, 1'b1);
        chk("t6b_const", 32'({i1.cout, i1.sum}), 32'h0FF);
`endif

        for (int n = 0; n < 24; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            rg = (n == 23) ? 1'b1 : 1'($urandom_range(0, 1));
            do_op(ra, rb, rc, rs, 1'b1, 0, rg);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
